// File: rtl/multi_tick_generator_pkg.sv
// Shared constants and config-request layout for the multi-channel tick generator.
package tick_gen_pkg;

   localparam int          NCH_DFLT     = 4;
   localparam int          W_DFLT       = 27;
   localparam int unsigned DEF_DIV_DFLT = 100_000_000;

   function automatic int chan_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   localparam int CHW_DFLT = chan_width(NCH_DFLT);

   typedef struct packed {
      logic [CHW_DFLT-1:0] chan;
      logic [W_DFLT-1:0]   div;
      logic                restart;
   } cfg_req_t;

endpackage

// File: rtl/multi_tick_generator_if.sv
// Divisor configuration port: valid/ready transfer of channel, divisor and restart flag.
interface multi_tick_generator_if
   import tick_gen_pkg::*;
#(
   parameter int NCH = NCH_DFLT,
   parameter int W   = W_DFLT
) ();

   localparam int CHW = chan_width(NCH);

   logic           cfg_valid;
   logic           cfg_ready;
   logic [CHW-1:0] cfg_chan;
   logic [W-1:0]   cfg_div;
   logic           cfg_restart;

   modport master (
      output cfg_valid,
      output cfg_chan,
      output cfg_div,
      output cfg_restart,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_chan,
      input  cfg_div,
      input  cfg_restart,
      output cfg_ready
   );

endinterface

// File: rtl/multi_tick_generator_channel.sv
// One clock-enable channel: counts to div_act-1, pulses tick and toggles sq at each wrap,
// and swaps in a shadow divisor at the wrap when one is pending.
module tick_channel
   import tick_gen_pkg::*;
#(
   parameter int          W       = W_DFLT,
   parameter int unsigned DEF_DIV = DEF_DIV_DFLT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         sync,
   input  logic         restart_hit,
   input  logic         shadow_hit,
   input  logic [W-1:0] cfg_div,
   output logic         tick,
   output logic         sq,
   output logic         pending
);

   localparam logic [W-1:0] DIV_RST = W'(DEF_DIV);

   logic [W-1:0] cnt;
   logic [W-1:0] div_act;
   logic [W-1:0] div_shd;
   logic         wrap;

   // div_act is never zero when this is used, so div_act-1 cannot underflow
   assign wrap = (cnt == div_act - W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         div_act <= DIV_RST;
         div_shd <= '0;
         pending <= 1'b0;
         tick    <= 1'b0;
         sq      <= 1'b0;
      end else if (restart_hit) begin
         div_act <= cfg_div;
         cnt     <= '0;
         tick    <= 1'b0;
         sq      <= 1'b0;
         pending <= 1'b0;
      end else begin
         if (!en || (div_act == '0)) begin
            cnt  <= '0;
            tick <= 1'b0;
         end else if (sync) begin
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
         end else if (wrap) begin
            cnt  <= '0;
            tick <= 1'b1;
            sq   <= ~sq;
            if (pending) begin
               div_act <= div_shd;
               pending <= 1'b0;
            end
         end else begin
            cnt  <= cnt + W'(1);
            tick <= 1'b0;
         end
         // Only accepted while pending is clear, so it never collides with the swap above
         if (shadow_hit) begin
            div_shd <= cfg_div;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/multi_tick_generator.sv
// NCH programmable tick / square-wave generators with a shared divisor config port.
module multi_tick_generator
   import tick_gen_pkg::*;
#(
   parameter int          NCH     = NCH_DFLT,
   parameter int          W       = W_DFLT,
   parameter int unsigned DEF_DIV = DEF_DIV_DFLT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       en,
   input  logic                 sync,
   multi_tick_generator_if.slave cfg,
   output logic [NCH-1:0]       tick,
   output logic [NCH-1:0]       sq,
   output logic [NCH-1:0]       pending
);

   localparam int CHW = chan_width(NCH);

   logic           sel_pending;
   logic           xfer;
   logic [NCH-1:0] restart_hit;
   logic [NCH-1:0] shadow_hit;

   // Channel numbers beyond NCH see no pending shadow, so they are accepted and dropped
   always_comb begin
      sel_pending = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (cfg.cfg_chan == CHW'(i)) begin
            sel_pending = pending[i];
         end
      end
   end

   assign cfg.cfg_ready = ~sel_pending | cfg.cfg_restart;
   assign xfer          = cfg.cfg_valid & cfg.cfg_ready;

   always_comb begin
      restart_hit = '0;
      shadow_hit  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (xfer && (cfg.cfg_chan == CHW'(i))) begin
            restart_hit[i] = cfg.cfg_restart;
            shadow_hit[i]  = ~cfg.cfg_restart;
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      tick_channel #(
         .W       (W),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .en          (en[g]),
         .sync        (sync),
         .restart_hit (restart_hit[g]),
         .shadow_hit  (shadow_hit[g]),
         .cfg_div     (cfg.cfg_div),
         .tick        (tick[g]),
         .sq          (sq[g]),
         .pending     (pending[g])
      );
   end

endmodule

// File: tb/tb_multi_tick_generator.sv
// Self-checking bench for multi_tick_generator with a phase-arithmetic reference model.
module tb_multi_tick_generator;

   localparam int NCH = 4;
   localparam int W   = 27;
   localparam int DEF = 8;

   logic           clk;
   logic           reset;
   logic [NCH-1:0] en;
   logic           sync;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] sq;
   logic [NCH-1:0] pending;

   multi_tick_generator_if #(.NCH(NCH), .W(W)) cfg_bus ();

   multi_tick_generator #(
      .NCH     (NCH),
      .W       (W),
      .DEF_DIV (DEF)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .sync    (sync),
      .cfg     (cfg_bus),
      .tick    (tick),
      .sq      (sq),
      .pending (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each channel ticks when (edge - start) mod d == d-1
   int       m_d     [NCH];
   int       m_shd   [NCH];
   int       m_start [NCH];
   bit       m_pend  [NCH];
   bit       m_tick  [NCH];
   bit       m_sq    [NCH];
   int       edge_n;
   logic [NCH-1:0] exp_tick, exp_sq, exp_pend;
   logic     exp_ready, obs_ready, last_acc;
   int       total, bad;

   function automatic void pack_exp();
      for (int i = 0; i < NCH; i++) begin
         exp_tick[i] = m_tick[i];
         exp_sq[i]   = m_sq[i];
         exp_pend[i] = m_pend[i];
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_d[i] = DEF; m_shd[i] = 0; m_start[i] = edge_n;
         m_pend[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
      end
      pack_exp();
   endfunction

   function automatic void model_step(input logic [NCH-1:0] en_c, input bit sync_c,
                                      input bit acc, input int chan_c, input int div_c,
                                      input bit rst_c);
      int cur;
      cur = edge_n;
      for (int i = 0; i < NCH; i++) begin
         if (acc && rst_c && chan_c == i) begin
            m_d[i] = div_c; m_pend[i] = 0; m_sq[i] = 0; m_tick[i] = 0; m_start[i] = cur + 1;
         end else begin
            if (!en_c[i] || m_d[i] == 0) begin
               m_tick[i] = 0; m_start[i] = cur + 1;
            end else if (sync_c) begin
               m_tick[i] = 0; m_sq[i] = 0; m_start[i] = cur + 1;
            end else if ((cur - m_start[i]) % m_d[i] == m_d[i] - 1) begin
               m_tick[i] = 1; m_sq[i] = !m_sq[i];
               if (m_pend[i]) begin
                  m_d[i] = m_shd[i]; m_pend[i] = 0; m_start[i] = cur + 1;
               end
            end else begin
               m_tick[i] = 0;
            end
            if (acc && !rst_c && chan_c == i) begin
               m_shd[i] = div_c; m_pend[i] = 1;
            end
         end
      end
      edge_n++;
      pack_exp();
   endfunction

   // Called just after a posedge; returns 1 time unit after the next posedge.
   task automatic advance();
      logic [NCH-1:0] en_c;
      bit sync_c, rst_c;
      int chan_c, div_c;
      #2;
      chan_c    = int'(cfg_bus.cfg_chan);
      div_c     = int'(cfg_bus.cfg_div);
      rst_c     = cfg_bus.cfg_restart;
      exp_ready = !m_pend[chan_c] || rst_c;
      obs_ready = cfg_bus.cfg_ready;
      last_acc  = cfg_bus.cfg_valid && exp_ready;
      en_c      = en;
      sync_c    = sync;
      @(posedge clk);
      model_step(en_c, sync_c, last_acc, chan_c, div_c, rst_c);
      #1;
   endtask

   task automatic set_cfg(input bit v, input int ch, input int d, input bit r);
      cfg_bus.cfg_valid   = v;
      cfg_bus.cfg_chan    = 2'(ch);
      cfg_bus.cfg_div     = W'(d);
      cfg_bus.cfg_restart = r;
   endtask

   task automatic test_reset();
      reset = 1'b0; en = '0; sync = 1'b0;
      set_cfg(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({tick, sq, pending} !== '0) begin
         bad++; $display("FAIL reset_outputs got=%b want=0", {tick, sq, pending});
      end
      en = '1;
      reset = 1'b1;
      edge_n = 0;
      model_reset();
   endtask

   task automatic test_default_div();
      int first, ntick, nhigh;
      first = -1; ntick = 0; nhigh = 0;
      for (int k = 0; k < 40; k++) begin
         advance();
         total++;
         if ({tick, sq, pending, obs_ready} !== {exp_tick, exp_sq, exp_pend, exp_ready}) begin
            bad++; $display("FAIL default_model k=%0d got=%b want=%b", k,
                            {tick, sq, pending, obs_ready}, {exp_tick, exp_sq, exp_pend, exp_ready});
         end
         if (tick[0] && first < 0) first = k;
         if (tick[0]) ntick++;
         if (k >= 7 && k < 39 && sq[0]) nhigh++;
         if (k == 7) begin
            total++;
            if (tick !== 4'hf) begin
               bad++; $display("FAIL default_all_tick got=%b want=1111", tick);
            end
         end
      end
      total++;
      if (first != 7) begin bad++; $display("FAIL default_first_tick got=%0d want=7", first); end
      total++;
      if (ntick != 5) begin bad++; $display("FAIL default_tick_count got=%0d want=5", ntick); end
      total++;
      if (nhigh != 16) begin bad++; $display("FAIL default_sq_duty got=%0d want=16", nhigh); end
   endtask

   task automatic test_div_one_zero();
      logic prev;
      set_cfg(1, 0, 1, 1); advance();
      set_cfg(1, 1, 0, 1); advance();
      set_cfg(0, 0, 0, 0);
      prev = sq[0];
      for (int k = 0; k < 12; k++) begin
         advance();
         total++;
         if ({tick, sq, pending, obs_ready} !== {exp_tick, exp_sq, exp_pend, exp_ready}) begin
            bad++; $display("FAIL div10_model k=%0d got=%b want=%b", k,
                            {tick, sq, pending, obs_ready}, {exp_tick, exp_sq, exp_pend, exp_ready});
         end
         total++;
         if (tick[0] !== 1'b1 || tick[1] !== 1'b0 || sq[0] === prev) begin
            bad++; $display("FAIL div10_shape k=%0d got tick01=%b%b sq0=%b prev=%b want tick01=01 toggle",
                            k, tick[0], tick[1], sq[0], prev);
         end
         prev = sq[0];
      end
   endtask

   task automatic test_shadow();
      int waited;
      bit done;
      set_cfg(1, 2, 8, 1); advance();
      set_cfg(0, 0, 0, 0);
      repeat (3) advance();
      set_cfg(1, 2, 3, 0); advance();
      total++;
      if (pending[2] !== 1'b1 || !last_acc) begin
         bad++; $display("FAIL shadow_pending got=%b want=1", pending[2]);
      end
      set_cfg(1, 2, 5, 0);
      waited = 0; done = 0;
      while (!done && waited < 20) begin
         advance();
         if (waited == 0) begin
            total++;
            if (obs_ready !== 1'b0) begin
               bad++; $display("FAIL shadow_ready_blocked got=%b want=0", obs_ready);
            end
         end
         total++;
         if ({tick, sq, pending, obs_ready} !== {exp_tick, exp_sq, exp_pend, exp_ready}) begin
            bad++; $display("FAIL shadow_model w=%0d got=%b want=%b", waited,
                            {tick, sq, pending, obs_ready}, {exp_tick, exp_sq, exp_pend, exp_ready});
         end
         done = last_acc;
         waited++;
      end
      total++;
      if (!done) begin bad++; $display("FAIL shadow_accept_timeout got=%0d want<20", waited); end
      set_cfg(0, 0, 0, 0);
      for (int k = 0; k < 30; k++) begin
         advance();
         total++;
         if ({tick, sq, pending, obs_ready} !== {exp_tick, exp_sq, exp_pend, exp_ready}) begin
            bad++; $display("FAIL shadow_run k=%0d got=%b want=%b", k,
                            {tick, sq, pending, obs_ready}, {exp_tick, exp_sq, exp_pend, exp_ready});
         end
      end
   endtask

   task automatic test_wrap_edge_cfg();
      set_cfg(1, 3, 6, 1); advance();
      set_cfg(0, 0, 0, 0);
      repeat (5) advance();
      set_cfg(1, 3, 4, 0); advance();
      total++;
      if (tick[3] !== 1'b1 || pending[3] !== 1'b1) begin
         bad++; $display("FAIL wrapcfg_edge got tick=%b pend=%b want 1 1", tick[3], pending[3]);
      end
      set_cfg(0, 0, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         advance();
         total++;
         if (tick[3] !== ((k == 6) || (k == 10)) || tick[3] !== exp_tick[3]) begin
            bad++; $display("FAIL wrapcfg_ticks k=%0d got=%b want=%b", k, tick[3], (k == 6) || (k == 10));
         end
      end
   endtask

   task automatic test_restart_pending();
      set_cfg(1, 1, 9, 0); advance();
      total++;
      if (pending[1] !== 1'b1) begin bad++; $display("FAIL restart_setup got=%b want=1", pending[1]); end
      set_cfg(1, 1, 5, 1); advance();
      total++;
      if (obs_ready !== 1'b1 || pending[1] !== 1'b0 || sq[1] !== 1'b0) begin
         bad++; $display("FAIL restart_accept got rdy=%b pend=%b sq=%b want 1 0 0",
                         obs_ready, pending[1], sq[1]);
      end
      set_cfg(0, 0, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         advance();
         total++;
         if (tick[1] !== (k == 5) || {tick, sq, pending} !== {exp_tick, exp_sq, exp_pend}) begin
            bad++; $display("FAIL restart_ticks k=%0d got=%b want tick1=%b", k, tick[1], k == 5);
         end
      end
   endtask

   task automatic test_sync();
      for (int c = 0; c < NCH; c++) begin
         set_cfg(1, c, 7, 1); advance();
      end
      set_cfg(0, 0, 0, 0);
      repeat (3) advance();
      sync = 1'b1; advance();
      sync = 1'b0;
      total++;
      if (sq !== '0 || tick !== '0) begin
         bad++; $display("FAIL sync_clear got sq=%b tick=%b want 0", sq, tick);
      end
      for (int k = 1; k <= 8; k++) begin
         advance();
         total++;
         if (tick !== ((k == 7) ? 4'hf : 4'h0) || tick !== exp_tick) begin
            bad++; $display("FAIL sync_align k=%0d got=%b want=%b", k, tick, (k == 7) ? 4'hf : 4'h0);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(7) != 0);
         sync = ($urandom_range(39) == 0);
         set_cfg($urandom_range(2) == 0, $urandom_range(3), $urandom_range(10), $urandom_range(3) == 0);
         advance();
         total++;
         if ({tick, sq, pending, obs_ready} !== {exp_tick, exp_sq, exp_pend, exp_ready}) begin
            bad++; $display("FAIL random_model k=%0d got=%b want=%b", k,
                            {tick, sq, pending, obs_ready}, {exp_tick, exp_sq, exp_pend, exp_ready});
         end
      end
      en = '1; sync = 1'b0;
      set_cfg(0, 0, 0, 0);
   endtask

   task automatic test_async_reset();
      set_cfg(1, 0, 2, 1); advance();
      set_cfg(0, 0, 0, 0);
      repeat (4) advance();
      #2;
      reset = 1'b0;
      #1;
      total++;
      if ({tick, sq, pending} !== '0) begin
         bad++; $display("FAIL async_reset got=%b want=0", {tick, sq, pending});
      end
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      for (int k = 0; k < 20; k++) begin
         advance();
         total++;
         if ({tick, sq, pending, obs_ready} !== {exp_tick, exp_sq, exp_pend, exp_ready}) begin
            bad++; $display("FAIL post_reset k=%0d got=%b want=%b", k,
                            {tick, sq, pending, obs_ready}, {exp_tick, exp_sq, exp_pend, exp_ready});
         end
      end
   endtask

   initial begin
      total = 0; bad = 0; edge_n = 0;
      model_reset();
      test_reset();
      test_default_div();
      test_div_one_zero();
      test_shadow();
      test_wrap_edge_cfg();
      test_restart_pending();
      test_sync();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
